// File: rtl/qpsk_bit_splitter.sv
// qpsk_bit_splitter: pairs serial bits into I/Q dibits, queues them and holds each for PERIOD cycles
module qpsk_bit_splitter #(
    parameter int PERIOD = 52,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic i_data,
    output logic q_data,
    output logic next1,
    output logic next2,
    output logic sym_start,
    output logic underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAST = 8'(PERIOD - 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic half, half_bit, push, pop, sym_nx, und_nx;
    assign din_ready = count < FULL;
    assign push = din_valid && din_ready && half;
    assign next2 = next1;
    always_comb begin
        state_nx = state;
        cnt_nx = '0;
        pop = 1'b0;
        sym_nx = 1'b0;
        und_nx = 1'b0;
        if (state == IDLE) begin
            pop = count != '0;
            sym_nx = pop;
            state_nx = pop ? RUN : IDLE;
        end else if (cnt == LAST) begin
            pop = count != '0;
            sym_nx = pop;
            und_nx = !pop;
            state_nx = pop ? RUN : IDLE;
        end else begin
            cnt_nx = cnt + 8'd1;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {half_bit, din};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            half <= 1'b0;
            half_bit <= 1'b0;
            i_data <= 1'b0;
            q_data <= 1'b0;
            next1 <= 1'b0;
            sym_start <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            next1 <= state_nx == RUN;
            sym_start <= sym_nx;
            underrun <= und_nx;
            if (din_valid && din_ready) half <= !half;
            if (din_valid && din_ready && !half) half_bit <= din;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pop) {i_data, q_data} <= mem[rd_ptr];
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// tb_qpsk_bit_splitter: random and directed stimulus checked against a queue-based transaction model
module tb_qpsk_bit_splitter;
    localparam int P = 52;
    localparam int D = 4;
    logic clk = 0, reset = 0, din = 0, din_valid = 0, d2 = 0, v2 = 0;
    logic din_ready, i_data, q_data, next1, next2, sym_start, underrun;
    logic r2, i2, q2, n1b, n2b, s2, u2;
    logic [6:0] got;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    assign got = {din_ready, i_data, q_data, next1, next2, sym_start, underrun};

    qpsk_bit_splitter #(.PERIOD(P), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .i_data(i_data), .q_data(q_data), .next1(next1), .next2(next2),
        .sym_start(sym_start), .underrun(underrun)
    );
    qpsk_bit_splitter #(.PERIOD(2), .DEPTH(D)) dut2 (
        .clk(clk), .reset(reset), .din(d2), .din_valid(v2), .din_ready(r2),
        .i_data(i2), .q_data(q2), .next1(n1b), .next2(n2b),
        .sym_start(s2), .underrun(u2)
    );

    // Model: dibit queue plus cycles left in the symbol on air
    logic [1:0] mfifo[$];
    bit mhalf, mhb, mact, mi, mqq, msym, mund;
    int mleft;

    function automatic void mreset();
        mfifo.delete();
        mhalf = 0; mhb = 0; mact = 0; mi = 0; mqq = 0; msym = 0; mund = 0; mleft = 0;
    endfunction

    function automatic bit medge(input bit v, input bit b);
        int sz;
        bit acc, start;
        logic [1:0] d;
        sz = mfifo.size();
        acc = v && sz < D;
        start = 0;
        msym = 0;
        mund = 0;
        if (!mact || mleft == 1) begin
            if (sz > 0) start = 1;
            else if (mact) begin mact = 0; mund = 1; end
        end else mleft--;
        if (start) begin
            d = mfifo.pop_front();
            mi = d[1]; mqq = d[0]; mact = 1; mleft = P; msym = 1;
        end
        if (acc) begin
            if (mhalf) begin mfifo.push_back({mhb, b}); mhalf = 0; end
            else begin mhb = b; mhalf = 1; end
        end
        return acc;
    endfunction

    function automatic logic [6:0] mexp();
        logic r;
        r = mfifo.size() < D;
        return {r, mi, mqq, mact, mact, msym, mund};
    endfunction

    task automatic step(input bit v, input bit b, output bit acc);
        din_valid = v;
        din = b;
        @(posedge clk);
        acc = medge(v, b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(negedge clk);
        mreset();
        if (got !== 7'b1000000) begin bad++; $display("FAIL reset_state got=%b exp=%b", got, 7'b1000000); end
        total++;
        reset = 1;
        #1;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", din_ready); end
        total++;
        if ({r2, i2, q2, n1b, n2b, s2, u2} !== 7'b1000000) begin bad++; $display("FAIL reset_state2 got=%b", {r2, i2, q2, n1b, n2b, s2, u2}); end
        total++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit acc;
        int n1c = 0, unc = 0;
        step(1, 1, acc);
        step(1, 0, acc);
        step(0, 0, acc);
        if ({sym_start, i_data, q_data, next1, next2} !== 5'b11011) begin
            bad++; $display("FAIL basic_start got=%b exp=%b", {sym_start, i_data, q_data, next1, next2}, 5'b11011);
        end
        total++;
        n1c = next1;
        for (int c = 0; c < 60; c++) begin
            step(0, 0, acc);
            if (got !== mexp()) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
            n1c += next1;
            unc += underrun;
        end
        if (n1c != P || unc != 1) begin bad++; $display("FAIL basic_len got=%0d/%0d exp=%0d/1", n1c, unc, P); end
        total++;
    endtask

    task automatic test_stream();
        bit s[8] = '{1, 1, 0, 0, 1, 0, 0, 1};
        logic [1:0] eiq[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        bit acc, v;
        int idx = 0, ns = 0, nu = 0;
        for (int c = 0; c < 4 * P + 12; c++) begin
            v = idx < 8;
            step(v, v ? s[idx] : 1'b0, acc);
            if (acc) idx++;
            if (got !== mexp()) begin bad++; $display("FAIL stream cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
            if (sym_start === 1'b1) begin
                if (ns < 4 && {i_data, q_data} !== eiq[ns]) begin
                    bad++; $display("FAIL stream_iq sym=%0d got=%b exp=%b", ns, {i_data, q_data}, eiq[ns]);
                end
                total++;
                ns++;
            end
            nu += underrun;
        end
        if (ns != 4 || nu != 1) begin bad++; $display("FAIL stream_counts got=%0d/%0d exp=4/1", ns, nu); end
        total++;
    endtask

    task automatic test_backpressure();
        bit s[12];
        bit acc, v;
        int idx = 0, ns = 0, lows = 0;
        for (int i = 0; i < 12; i++) s[i] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 6 * P + 30; c++) begin
            v = idx < 12;
            step(v, v ? s[idx] : 1'b0, acc);
            if (acc) idx++;
            if (got !== mexp()) begin bad++; $display("FAIL bp cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
            lows += !din_ready;
            if (sym_start === 1'b1) begin
                if (ns < 6 && {i_data, q_data} !== {s[2*ns], s[2*ns+1]}) begin
                    bad++; $display("FAIL bp_order sym=%0d got=%b exp=%b", ns, {i_data, q_data}, {s[2*ns], s[2*ns+1]});
                end
                total++;
                ns++;
            end
        end
        if (idx != 12 || ns != 6 || lows == 0) begin bad++; $display("FAIL bp_counts got=%0d/%0d/%0d exp=12/6/>0", idx, ns, lows); end
        total++;
    endtask

    task automatic test_half_bit();
        bit acc;
        int act = 0;
        step(1, 1, acc);
        for (int c = 0; c < 70; c++) begin
            step(0, 0, acc);
            if (got !== mexp()) begin bad++; $display("FAIL half cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
            act += next1 + underrun;
        end
        if (act != 0) begin bad++; $display("FAIL half_idle got=%0d exp=0", act); end
        total++;
        step(1, 1, acc);
        step(0, 0, acc);
        if ({sym_start, i_data, q_data, next1} !== 4'b1111) begin
            bad++; $display("FAIL half_pair got=%b exp=1111", {sym_start, i_data, q_data, next1});
        end
        total++;
        for (int c = 0; c < P + 4; c++) begin
            step(0, 0, acc);
            if (got !== mexp()) begin bad++; $display("FAIL half_drain cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
        end
    endtask

    task automatic test_reset_mid();
        bit s[8];
        bit acc, v;
        int idx = 0, c = 0, act = 0;
        for (int i = 0; i < 8; i++) s[i] = 1'($urandom_range(0, 1));
        while (!(idx == 8 && mact && mleft == P - 20) && c < 300) begin
            v = idx < 8;
            step(v, v ? s[idx] : 1'b0, acc);
            if (acc) idx++;
            if (got !== mexp()) begin bad++; $display("FAIL rmid cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
            c++;
        end
        if (c >= 300 || mfifo.size() != 3) begin bad++; $display("FAIL rmid_setup cyc=%0d queued=%0d exp=3", c, mfifo.size()); end
        total++;
        reset = 0;
        #1;
        if (got !== 7'b1000000) begin bad++; $display("FAIL rmid_async got=%b exp=%b", got, 7'b1000000); end
        total++;
        mreset();
        @(negedge clk);
        reset = 1;
        for (int k = 0; k < 70; k++) begin
            step(0, 0, acc);
            if (got !== mexp()) begin bad++; $display("FAIL rmid_after cyc=%0d got=%b exp=%b", k, got, mexp()); end
            total++;
            act += next1 + underrun;
        end
        if (act != 0) begin bad++; $display("FAIL rmid_quiet got=%0d exp=0", act); end
        total++;
    endtask

    task automatic test_random();
        bit acc;
        int pct;
        for (int c = 0; c < 800 + (D + 1) * (P + 1); c++) begin
            pct = c < 300 ? 8 : (c < 800 ? 85 : 0);
            step(($urandom_range(0, 99) < pct), 1'($urandom_range(0, 1)), acc);
            if (got !== mexp()) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, got, mexp()); end
            total++;
        end
    endtask

    task automatic test_period2();
        bit b[6] = '{1, 0, 0, 1, 1, 1};
        logic [6:0] e[10] = '{7'b1000000, 7'b1000000, 7'b1111100, 7'b1110100, 7'b1111010,
                              7'b1110010, 7'b1111110, 7'b1110110, 7'b1000111, 7'b1000110};
        bit acc;
        for (int k = 0; k < 10; k++) begin
            v2 = k < 6;
            d2 = k < 6 ? b[k] : 1'b0;
            step(0, 0, acc);
            if ({r2, n1b, n2b, s2, i2, q2, u2} !== e[k]) begin
                bad++; $display("FAIL period2 cyc=%0d got=%b exp=%b", k, {r2, n1b, n2b, s2, i2, q2, u2}, e[k]);
            end
            total++;
        end
        v2 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_half_bit();
        test_reset_mid();
        test_random();
        test_period2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qpsk_bit_splitter.md
QPSK_BIT_SPLITTER -- requirements
Module: qpsk_bit_splitter

Interface
REQ-001 Parameter PERIOD, default 52: carrier samples per symbol, i.e. clock cycles each dibit is held; legal range 2..255.
REQ-002 Parameter DEPTH, default 4: dibit FIFO entries; legal values 2, 4 or 8.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 din  in  1  serial data bit; the first bit of each pair is I, the second is Q.
REQ-006 din_valid  in  1  din is valid this cycle.
REQ-007 din_ready  out  1  block accepts din this cycle.
REQ-008 i_data  out  1  I bit of the current symbol; drives the data input of the I-branch carrier generator.
REQ-009 q_data  out  1  Q bit of the current symbol; drives the data input of the Q-branch carrier generator.
REQ-010 next1  out  1  symbol active; high for every cycle of a transmitted symbol.
REQ-011 next2  out  1  sample enable; equal to next1 in every cycle.
REQ-012 sym_start  out  1  one-cycle pulse in the first cycle of each symbol.
REQ-013 underrun  out  1  one-cycle pulse when a symbol ends and the FIFO is empty.

Function
REQ-014 A bit is accepted on a rising edge where din_valid && din_ready.
REQ-015 din_ready SHALL be combinational and equal (fifo_count < DEPTH), using the registered count.
REQ-016 Pairing, first accepted bit: it is stored in a half register and the half flag is set.
REQ-017 Pairing, second accepted bit: the FIFO receives {I=half register, Q=din} and the half flag is cleared.
REQ-018 A push and a pop on the same edge SHALL both occur; fifo_count SHALL be unchanged.
REQ-019 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-020 A push attempted when the FIFO is full cannot occur; no bit is lost while din_ready is low.
REQ-021 The block SHALL have a two-state FSM: IDLE and RUN.
REQ-022 IDLE: the symbol counter is held at 0 and next1, next2 and sym_start are 0.
REQ-023 IDLE with fifo_count > 0: pop the head entry and load i_data/q_data.
REQ-024 IDLE with fifo_count > 0: set next1 = next2 = 1, pulse sym_start, enter RUN with counter = 0.
REQ-025 RUN: the counter increments each cycle from 0 to PERIOD-1.
REQ-026 RUN at counter = PERIOD-1 with FIFO non-empty: pop and load the next dibit, counter to 0, pulse sym_start, stay in RUN.
REQ-027 The transition between back-to-back symbols SHALL be gapless; next1 stays high.
REQ-028 RUN at counter = PERIOD-1 with FIFO empty: go to IDLE, set next1 = next2 = 0, pulse underrun.
REQ-029 i_data and q_data SHALL hold their last values through IDLE.
REQ-030 Each symbol SHALL keep next1 high for exactly PERIOD cycles.
REQ-031 Latency: the dibit that completes on push edge E (FIFO previously empty, FSM in IDLE) is loaded on edge E+1.
REQ-032 next1 and sym_start SHALL be high in the cycle after edge E+1.
REQ-033 A dangling half bit SHALL stay in the half register indefinitely and is never transmitted alone.
REQ-034 All outputs except din_ready SHALL be registered.

Reset
REQ-035 reset low SHALL immediately force: i_data, q_data, next1, next2, sym_start and underrun to 0.
REQ-036 reset low SHALL immediately force: FSM to IDLE, counter to 0, FIFO pointers and count to 0, half flag to 0.
REQ-037 Reset asserted mid-symbol SHALL discard the FIFO contents and the half bit.
REQ-038 din_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-039 Bits 1,0 sent back-to-back after reset -> i_data=1, q_data=0, sym_start=1 two edges after the second bit; next1=next2=1 for exactly 52 cycles; then underrun pulses once and next1=0.
REQ-040 Dibits 11,00,10,01 streamed continuously -> four gapless 52-cycle symbols with (i,q) = (1,1),(0,0),(1,0),(0,1); sym_start every 52 cycles; one underrun after the last symbol.
REQ-041 din_valid held high with 12 bits while PERIOD=52 -> din_ready drops when fifo_count=4; it re-rises exactly one cycle after each pop; every bit is transmitted in order.
REQ-042 Single bit 1 sent with no second bit -> next1 stays 0 and no underrun.
REQ-043 Follow-on to REQ-042: a later bit 1 is sent -> symbol (1,1) starts.
REQ-044 reset pulsed low at counter=20 of a symbol with 3 dibits queued -> all outputs 0 immediately; after release, next1 stays 0 until new input arrives.
REQ-045 PERIOD=2 with the FIFO pre-filled with 3 dibits -> symbols of 2 cycles each, sym_start on alternate cycles, no gaps.
